// File: rtl/wash_cycle_sequencer_if.sv
// Panel-side inputs and actuator/status outputs of the wash cycle sequencer.
// The master drives the panel inputs and the slave is the sequencer itself.
interface wash_cycle_sequencer_if;
  logic       tick_1s;
  logic       run_pulse;
  logic       lid_open;
  logic [2:0] prog_sel;
  logic [1:0] water_lvl;
  logic       valve_in;
  logic       valve_out;
  logic       motor_wash;
  logic       motor_spin;
  logic [3:0] phase;
  logic [7:0] phase_left;
  logic [7:0] total_left;
  logic       running;
  logic       done_beep;

  modport master (
    output tick_1s, run_pulse, lid_open, prog_sel, water_lvl,
    input  valve_in, valve_out, motor_wash, motor_spin,
           phase, phase_left, total_left, running, done_beep
  );

  modport slave (
    input  tick_1s, run_pulse, lid_open, prog_sel, water_lvl,
    output valve_in, valve_out, motor_wash, motor_spin,
           phase, phase_left, total_left, running, done_beep
  );
endinterface

// File: rtl/wash_cycle_sequencer.sv
// Washer program sequencer: steps fill/wash/drain/rinse/spin/dry phases from a 1 s tick,
// owns run/pause and the lid interlock, and decodes valve/motor enables.
module wash_cycle_sequencer #(
  parameter int FILL_T  = 2,
  parameter int WASH_T  = 9,
  parameter int RINSE_T = 6,
  parameter int DRAIN_T = 3,
  parameter int SPIN_T  = 3,
  parameter int DRY_T   = 5,
  parameter int BEEP_T  = 3
) (
  input logic                   clk,
  input logic                   in_resetBtn,
  wash_cycle_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    W_FILL  = 4'd1,
    WASH    = 4'd2,
    W_DRAIN = 4'd3,
    R_FILL  = 4'd4,
    RINSE   = 4'd5,
    R_DRAIN = 4'd6,
    R_SPIN  = 4'd7,
    D_SPIN  = 4'd8,
    DONE    = 4'd9
  } phase_e;

  phase_e     state;
  logic [7:0] phaseLeft;
  logic [7:0] totalLeft;
  logic [7:0] fillTime;
  logic [2:0] selLatch;
  logic       runFlag;
  logic       beep;

  // Successor of a phase, skipping program blocks whose select bit is clear.
  function automatic phase_e nextPhase(phase_e cur, logic [2:0] sel);
    phase_e nxt;
    nxt = DONE;
    case (cur)
      IDLE: begin
        if (sel[2])      nxt = W_FILL;
        else if (sel[1]) nxt = R_FILL;
        else if (sel[0]) nxt = D_SPIN;
      end
      W_FILL:  nxt = WASH;
      WASH:    nxt = W_DRAIN;
      W_DRAIN: begin
        if (sel[1])      nxt = R_FILL;
        else if (sel[0]) nxt = D_SPIN;
      end
      R_FILL:  nxt = RINSE;
      RINSE:   nxt = R_DRAIN;
      R_DRAIN: nxt = R_SPIN;
      R_SPIN:  if (sel[0]) nxt = D_SPIN;
      default: nxt = DONE;
    endcase
    return nxt;
  endfunction

  function automatic logic [7:0] phaseTime(phase_e p, logic [7:0] fill);
    logic [7:0] t;
    t = 8'd0;
    case (p)
      W_FILL, R_FILL:   t = fill;
      WASH:             t = 8'(WASH_T);
      RINSE:            t = 8'(RINSE_T);
      W_DRAIN, R_DRAIN: t = 8'(DRAIN_T);
      R_SPIN:           t = 8'(SPIN_T);
      D_SPIN:           t = 8'(DRY_T);
      default:          t = 8'd0;
    endcase
    return t;
  endfunction

  logic [7:0] startFill;
  logic [7:0] startTotal;
  phase_e     startPhase;
  phase_e     advPhase;
  logic       startOk;
  logic       active;

  assign startFill  = 8'(FILL_T) * (8'(bus.water_lvl) + 8'd1);
  assign startTotal = (bus.prog_sel[2] ? startFill + 8'(WASH_T) + 8'(DRAIN_T) : 8'd0)
                    + (bus.prog_sel[1] ? startFill + 8'(RINSE_T) + 8'(DRAIN_T) + 8'(SPIN_T) : 8'd0)
                    + (bus.prog_sel[0] ? 8'(DRY_T) : 8'd0);
  assign startPhase = nextPhase(IDLE, bus.prog_sel);
  assign advPhase   = nextPhase(state, selLatch);
  assign startOk    = bus.run_pulse && (bus.prog_sel != 3'b000) && !bus.lid_open;
  assign active     = runFlag && !bus.lid_open && (state >= W_FILL) && (state <= D_SPIN);

  // NOTE: every register updates with <= so all branches see pre-edge values, which is what
  // lets a run_pulse and a tick in the same cycle both act on the old 'active'.
  always_ff @(posedge clk or negedge in_resetBtn) begin
    if (!in_resetBtn) begin
      state     <= IDLE;
      phaseLeft <= 8'd0;
      totalLeft <= 8'd0;
      fillTime  <= 8'd0;
      selLatch  <= 3'b000;
      runFlag   <= 1'b0;
      beep      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startOk) begin
            selLatch  <= bus.prog_sel;
            fillTime  <= startFill;
            state     <= startPhase;
            phaseLeft <= phaseTime(startPhase, startFill);
            totalLeft <= startTotal;
            runFlag   <= 1'b1;
          end
        end
        DONE: begin
          // Beep countdown reuses phaseLeft; a run press cuts it short.
          if (bus.run_pulse || (bus.tick_1s && phaseLeft <= 8'd1)) begin
            state     <= IDLE;
            beep      <= 1'b0;
            phaseLeft <= 8'd0;
          end else if (bus.tick_1s) begin
            phaseLeft <= phaseLeft - 8'd1;
          end
        end
        default: begin
          if (bus.run_pulse) runFlag <= !runFlag;
          if (bus.tick_1s && active) begin
            totalLeft <= (totalLeft != 8'd0) ? totalLeft - 8'd1 : 8'd0;
            if (phaseLeft > 8'd1) begin
              phaseLeft <= phaseLeft - 8'd1;
            end else begin
              state <= advPhase;
              if (advPhase == DONE) begin
                phaseLeft <= 8'(BEEP_T);
                beep      <= 1'b1;
                runFlag   <= 1'b0;
              end else begin
                phaseLeft <= phaseTime(advPhase, fillTime);
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.valve_in   = active && (state == W_FILL || state == R_FILL);
  assign bus.valve_out  = active && (state == W_DRAIN || state == R_DRAIN ||
                                     state == R_SPIN  || state == D_SPIN);
  assign bus.motor_wash = active && (state == WASH || state == RINSE);
  assign bus.motor_spin = active && (state == R_SPIN || state == D_SPIN);
  assign bus.phase      = state;
  assign bus.phase_left = phaseLeft;
  assign bus.total_left = totalLeft;
  assign bus.running    = runFlag;
  assign bus.done_beep  = beep;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench for wash_cycle_sequencer: full program walk, dry-only, pause, lid interlock,
// async reset and rejected starts, all against hand-computed values.
module tb_wash_cycle_sequencer;

  logic clk = 1'b0;
  logic in_resetBtn = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  wash_cycle_sequencer_if bus ();

  wash_cycle_sequencer dut (
    .clk         (clk),
    .in_resetBtn (in_resetBtn),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    testsRun++;
    if (obs != exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulseRun();
    @(negedge clk) bus.run_pulse = 1'b1;
    @(negedge clk) bus.run_pulse = 1'b0;
  endtask

  // One second = 10 clocks, tick high for the first of them.
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) bus.tick_1s = 1'b1;
      @(negedge clk) bus.tick_1s = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  function automatic int acts();
    return {bus.valve_in, bus.valve_out, bus.motor_wash, bus.motor_spin};
  endfunction

  // Full program: phase code, length, {valve_in,valve_out,motor_wash,motor_spin}
  int phaseCode [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int phaseLen  [8] = '{4, 9, 3, 4, 6, 3, 3, 5};
  int phaseAct  [8] = '{4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b0101, 4'b0101};

  initial begin
    int totalExp;
    bus.tick_1s   = 1'b0;
    bus.run_pulse = 1'b0;
    bus.lid_open  = 1'b0;
    bus.prog_sel  = 3'b000;
    bus.water_lvl = 2'd0;

    #12;
    check("reset_phase", bus.phase, 0);
    check("reset_running", bus.running, 0);
    check("reset_total", bus.total_left, 0);
    check("reset_acts", acts(), 0);
    @(negedge clk) in_resetBtn = 1'b1;

    // Full program 111, water level 1
    bus.prog_sel  = 3'b111;
    bus.water_lvl = 2'd1;
    pulseRun();
    check("full_start_total", bus.total_left, 37);
    check("full_start_running", bus.running, 1);
    totalExp = 37;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_phase%0d_code", i), bus.phase, phaseCode[i]);
      check($sformatf("full_phase%0d_left", i), bus.phase_left, phaseLen[i]);
      check($sformatf("full_phase%0d_acts", i), acts(), phaseAct[i]);
      check($sformatf("full_phase%0d_total", i), bus.total_left, totalExp);
      ticks(phaseLen[i]);
      totalExp -= phaseLen[i];
    end
    check("full_done_phase", bus.phase, 9);
    check("full_done_beep", bus.done_beep, 1);
    check("full_done_running", bus.running, 0);
    check("full_done_total", bus.total_left, 0);
    check("full_done_acts", acts(), 0);
    ticks(2);
    check("full_beep_hold", bus.done_beep, 1);
    ticks(1);
    check("full_idle_phase", bus.phase, 0);
    check("full_idle_beep", bus.done_beep, 0);

    // Dry only
    bus.prog_sel = 3'b001;
    pulseRun();
    check("dry_phase", bus.phase, 8);
    check("dry_total", bus.total_left, 5);
    check("dry_acts", acts(), 4'b0101);
    ticks(4);
    check("dry_phase_late", bus.phase, 8);
    check("dry_acts_late", acts(), 4'b0101);
    check("dry_total_late", bus.total_left, 1);
    ticks(1);
    check("dry_done", bus.phase, 9);
    pulseRun();
    check("dry_run_in_done_phase", bus.phase, 0);
    check("dry_run_in_done_beep", bus.done_beep, 0);

    // Wash only, level 0: pause in WASH at phase_left=5, latched program
    bus.prog_sel  = 3'b100;
    bus.water_lvl = 2'd0;
    pulseRun();
    check("wash_total", bus.total_left, 14);
    check("wash_fill_left", bus.phase_left, 2);
    bus.prog_sel = 3'b111;
    ticks(2);
    check("wash_phase", bus.phase, 2);
    ticks(4);
    check("wash_left5", bus.phase_left, 5);
    pulseRun();
    check("pause_running", bus.running, 0);
    check("pause_motor", bus.motor_wash, 0);
    ticks(10);
    check("pause_left", bus.phase_left, 5);
    check("pause_total", bus.total_left, 8);
    check("pause_phase", bus.phase, 2);
    pulseRun();
    check("resume_running", bus.running, 1);
    check("resume_motor", bus.motor_wash, 1);
    check("resume_left", bus.phase_left, 5);
    ticks(1);
    check("resume_count", bus.phase_left, 4);
    check("resume_total", bus.total_left, 7);
    ticks(4);
    check("wash_drain", bus.phase, 3);
    ticks(3);
    check("wash_latched_done", bus.phase, 9);
    pulseRun();

    // Rinse only, level 2: lid interlock in R_FILL
    bus.prog_sel  = 3'b010;
    bus.water_lvl = 2'd2;
    pulseRun();
    check("rinse_total", bus.total_left, 18);
    check("rinse_fill_left", bus.phase_left, 6);
    ticks(1);
    @(negedge clk) bus.lid_open = 1'b1;
    #1;
    check("lid_valve_in", bus.valve_in, 0);
    check("lid_running", bus.running, 1);
    ticks(3);
    check("lid_left", bus.phase_left, 5);
    check("lid_total", bus.total_left, 17);
    check("lid_phase", bus.phase, 4);
    @(negedge clk) bus.lid_open = 1'b0;
    #1;
    check("lid_closed_valve_in", bus.valve_in, 1);
    ticks(1);
    check("lid_resume_left", bus.phase_left, 4);
    check("lid_resume_total", bus.total_left, 16);
    ticks(4);
    check("rinse_phase", bus.phase, 5);
    check("rinse_motor", bus.motor_wash, 1);

    // Async reset mid RINSE, between clock edges
    @(negedge clk);
    #2 in_resetBtn = 1'b0;
    #1;
    check("arst_phase", bus.phase, 0);
    check("arst_acts", acts(), 0);
    check("arst_running", bus.running, 0);
    check("arst_left", bus.phase_left, 0);
    check("arst_total", bus.total_left, 0);
    @(negedge clk) in_resetBtn = 1'b1;
    ticks(2);
    check("arst_stays_idle", bus.phase, 0);

    // Rejected starts
    bus.prog_sel = 3'b000;
    pulseRun();
    check("nosel_phase", bus.phase, 0);
    check("nosel_running", bus.running, 0);
    bus.prog_sel = 3'b111;
    bus.lid_open = 1'b1;
    pulseRun();
    check("lidstart_phase", bus.phase, 0);
    check("lidstart_running", bus.running, 0);
    bus.lid_open = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
